// File: rtl/babbage_pkg.sv
// Shared defaults and FSM state type for the finite-difference cubic evaluator.
package babbage_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int YW_DEFAULT = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/babbage.sv
// Evaluates a3*x^3+a2*x^2+a1*x+a0 by forward differences, adds only.
// Latency: x+1 edges from the capture edge to the edge raising valid.
// Backpressure: none; x_val is accepted only in IDLE, ignored while busy.
module babbage
    import babbage_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int YW = YW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a3,
    input  logic [DW-1:0] a2,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] x,
    input  logic          x_val,
    output logic          valid,
    output logic [YW-1:0] y
);

    state_t        state;
    logic [YW-1:0] f;
    logic [YW-1:0] d1;
    logic [YW-1:0] d2;
    logic [YW-1:0] d3;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            y     <= '0;
            f     <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_val) begin
                        // Differences of the cubic at 0: d1=f(1)-f(0), d2=6a3+2a2, d3=6a3.
                        f     <= YW'(a0);
                        d1    <= YW'(a3) + YW'(a2) + YW'(a1);
                        d2    <= (YW'(a3) << 2) + (YW'(a3) << 1) + (YW'(a2) << 1);
                        d3    <= (YW'(a3) << 2) + (YW'(a3) << 1);
                        cnt   <= x;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        f   <= f + d1;
                        d1  <= d1 + d2;
                        d2  <= d2 + d3;
                        cnt <= cnt - DW'(1);
                    end else begin
                        y     <= f;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_babbage.sv
// Directed-vector and corner-sequence bench for the babbage cubic evaluator.
module tb_babbage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a3, a2, a1, a0, x;
    logic        x_val;
    logic        valid;
    logic [32:0] y;

    int n_err = 0;
    int n_chk = 0;

    babbage dut (
        .clk   (clk),
        .rst   (rst),
        .a3    (a3),
        .a2    (a2),
        .a1    (a1),
        .a0    (a0),
        .x     (x),
        .x_val (x_val),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  a3;
        logic [7:0]  a2;
        logic [7:0]  a1;
        logic [7:0]  a0;
        logic [63:0] y;
        int          edges;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Capture one operand set, scramble inputs after capture, then time and check the result.
    task automatic run_vec(input string name, input logic [7:0] vx, input logic [7:0] v3,
                           input logic [7:0] v2, input logic [7:0] v1, input logic [7:0] v0,
                           input logic [63:0] exp_y, input int exp_edges);
        int n;
        x = vx; a3 = v3; a2 = v2; a1 = v1; a0 = v0;
        x_val = 1'b1;
        step();
        x_val = 1'b0;
        x = 8'($urandom); a3 = 8'($urandom); a2 = 8'($urandom);
        a1 = 8'($urandom); a0 = 8'($urandom);
        n = 1;
        while (!valid && n < 400) begin
            step();
            n++;
        end
        chk({name, " edges"}, 64'(n), 64'(exp_edges));
        chk({name, " y"}, 64'(y), exp_y);
        step();
        chk({name, " valid width"}, 64'(valid), 64'd0);
    endtask

    initial begin
        logic [63:0] gy;
        logic [7:0]  rx, r3, r2, r1, r0;
        int          seen;

        vecs[0] = '{8'd0,   8'd9,   8'd8,   8'd7,   8'd5,   64'd5,          2};
        vecs[1] = '{8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   64'd4,          3};
        vecs[2] = '{8'd5,   8'd127, 8'd127, 8'd127, 8'd127, 64'd19812,      7};
        vecs[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 64'd4244897280, 257};
        vecs[4] = '{8'd2,   8'd1,   8'd2,   8'd3,   8'd4,   64'd26,         4};
        vecs[5] = '{8'd3,   8'd0,   8'd0,   8'd0,   8'd0,   64'd0,          5};
        vecs[6] = '{8'd4,   8'd2,   8'd0,   8'd0,   8'd1,   64'd129,        6};
        vecs[7] = '{8'd10,  8'd0,   8'd1,   8'd0,   8'd0,   64'd100,        12};
        vecs[8] = '{8'd3,   8'd1,   8'd0,   8'd0,   8'd0,   64'd27,         5};

        // Reset with x_val held high: nothing is captured during reset.
        rst = 1'b1; x_val = 1'b1;
        x = 8'd0; a3 = 8'd0; a2 = 8'd0; a1 = 8'd0; a0 = 8'd3;
        step(); step(); step();
        chk("reset valid", 64'(valid), 64'd0);
        chk("reset y", 64'(y), 64'd0);
        rst = 1'b0;
        step();
        chk("first capture edge valid", 64'(valid), 64'd0);
        x_val = 1'b0;
        step();
        chk("post-reset capture valid", 64'(valid), 64'd1);
        chk("post-reset capture y", 64'(y), 64'd3);
        step();
        chk("post-reset valid drop", 64'(valid), 64'd0);
        step();

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].x, vecs[i].a3, vecs[i].a2,
                    vecs[i].a1, vecs[i].a0, vecs[i].y, vecs[i].edges);
        step();
        chk("y holds between pulses", 64'(y), 64'd27);

        // Strobe during RUN is ignored; only one result appears.
        x = 8'd5; a3 = 8'd127; a2 = 8'd127; a1 = 8'd127; a0 = 8'd127;
        x_val = 1'b1;
        step();
        x_val = 1'b0;
        step();
        x = 8'd2; a3 = 8'd1; a2 = 8'd1; a1 = 8'd1; a0 = 8'd1;
        x_val = 1'b1;
        step();
        x_val = 1'b0;
        seen = 0;
        for (int e = 3; e <= 20; e++) begin
            if (valid) begin
                seen++;
                chk("busy strobe edge", 64'(e), 64'd7);
                chk("busy strobe y", 64'(y), 64'd19812);
            end
            step();
        end
        chk("busy strobe pulses", 64'(seen), 64'd1);

        // Reset mid-RUN aborts with no pulse.
        x = 8'd5; a3 = 8'd127; a2 = 8'd127; a1 = 8'd127; a0 = 8'd127;
        x_val = 1'b1;
        step();
        x_val = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort valid", 64'(valid), 64'd0);
        chk("abort y", 64'(y), 64'd0);
        seen = 0;
        for (int e = 0; e < 15; e++) begin
            if (valid) seen++;
            step();
        end
        chk("abort no pulse", 64'(seen), 64'd0);

        // x_val held high: DONE ignores it, following IDLE accepts it.
        x = 8'd0; a3 = 8'd0; a2 = 8'd0; a1 = 8'd0; a0 = 8'd7;
        x_val = 1'b1;
        step();
        a0 = 8'd9;
        chk("b2b e1", 64'(valid), 64'd0);
        step();
        chk("b2b e2 valid", 64'(valid), 64'd1);
        chk("b2b e2 y", 64'(y), 64'd7);
        step();
        chk("b2b e3", 64'(valid), 64'd0);
        step();
        chk("b2b e4", 64'(valid), 64'd0);
        x_val = 1'b0;
        step();
        chk("b2b e5 valid", 64'(valid), 64'd1);
        chk("b2b e5 y", 64'(y), 64'd9);
        step();
        chk("b2b e6", 64'(valid), 64'd0);

        // Random operands with random idle gaps.
        for (int r = 0; r < 25; r++) begin
            rx = 8'($urandom_range(0, 5));
            r3 = 8'($urandom_range(0, 127)); r2 = 8'($urandom_range(0, 127));
            r1 = 8'($urandom_range(0, 127)); r0 = 8'($urandom_range(0, 127));
            gy = 64'(r3) * 64'(rx) * 64'(rx) * 64'(rx) + 64'(r2) * 64'(rx) * 64'(rx)
               + 64'(r1) * 64'(rx) + 64'(r0);
            run_vec($sformatf("rand%0d", r), rx, r3, r2, r1, r0, gy, int'(rx) + 2);
            for (int g = $urandom_range(0, 5); g > 0; g--) step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/babbage.md
BABBAGE -- requirements
Module: babbage

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the width of the coefficients and of x.
REQ-002 The block SHALL have parameter YW, default 33, meaning the width of the result and of the internal accumulators.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Ports a3, a2, a1, a0, inputs, DW bits each: unsigned polynomial coefficients.
REQ-006 Port x, input, DW bits: unsigned evaluation point.
REQ-007 Port x_val, input, 1 bit: start strobe that qualifies a3..a0 and x.
REQ-008 Port valid, output, 1 bit: result strobe, registered.
REQ-009 Port y, output, YW bits: result, registered.

Function
REQ-010 y SHALL equal a3*x^3 + a2*x^2 + a1*x + a0 for the operands captured at start. All arithmetic is unsigned and exact; the maximum 255*(255^3+255^2+255+1) fits in 33 bits.
REQ-011 Evaluation SHALL use the method of finite differences, with additions only and no multiplier on the datapath, except for the constant-by-small-integer initialisation.
REQ-012 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE, with x_val=1 at a rising edge, the block SHALL load:
 - f = a0
 - d1 = a3+a2+a1
 - d2 = 6*a3+2*a2
 - d3 = 6*a3
 - cnt = x
 It SHALL then go to RUN.
REQ-014 In RUN with cnt != 0, each edge SHALL perform f+=d1, d1+=d2, d2+=d3 (all in parallel, using old values) and cnt-=1.
REQ-015 In RUN with cnt == 0, the edge SHALL load y=f, set valid=1 and go to DONE.
REQ-016 In DONE, the next edge SHALL clear valid and return to IDLE.
REQ-017 valid SHALL be high for exactly one cycle per accepted x_val.
REQ-018 Latency: if x_val is sampled at edge k, valid SHALL be high from edge k+x+1 to edge k+x+2.
REQ-019 With x=0, the first RUN edge SHALL produce valid, so y=a0 after 2 edges.
REQ-020 x_val SHALL be ignored in RUN and DONE; there is no queueing.
REQ-021 x_val in the IDLE cycle immediately after DONE SHALL be accepted normally.
REQ-022 The operands need not stay stable after the capture edge; the internal registers alone determine the result.
REQ-023 y SHALL hold its last result between valid pulses and SHALL change only at the edge that raises valid.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL:
 - enter IDLE
 - set valid=0, y=0
 - clear f, d1, d2, d3 and cnt
REQ-025 Reset SHALL have priority over x_val and over any operation in progress.
REQ-026 A reset during RUN SHALL abort the operation with no valid pulse.
REQ-027 x_val held high during reset SHALL be ignored; the first capture SHALL occur at the first edge with rst=0.

Structure
REQ-028 A package babbage_pkg SHALL hold the DW and YW defaults and the state enum type (IDLE, RUN, DONE).
REQ-029 The block SHALL be a single module with no sub-modules; the difference registers and counter stay inline.

Verification
REQ-030 Case x=0, a3..a0=9,8,7,5 -> valid after 2 edges, y=5.
REQ-031 Case x=1, a3..a0=1,1,1,1 -> valid after 3 edges, y=4.
REQ-032 Case x=5, all coefficients=127 -> valid after 7 edges, y=19812; valid is high for exactly one cycle.
REQ-033 Case x=255, all coefficients=255 -> y=4244897280 after 257 edges.
REQ-034 Case start with x=5; pulse x_val with x=2 during RUN; assert rst mid-RUN on a repeat run:
 - the second strobe is ignored and the first result is correct;
 - after rst: valid=0, y=0, and no valid pulse follows.
REQ-035 Random case: x in 0..5, coefficients in 0..127, random idle gaps of 0..5 cycles, inputs changed right after capture -> every valid pulse matches the golden polynomial of the captured operands.
